// File: rtl/spi_master_controller.sv
// SPI master sequencer: runs one mode-0, 8-bit full-duplex transfer per START,
// driving the sender/receiver shift-register controls, SCLK and CS_N.
module spi_master_controller #(
    parameter int HALF_DIV = 4
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       START,
    input  logic [7:0] TX_DATA,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RX_DATA,
    output logic       ERR,
    output logic       SCLK,
    output logic       CS_N,
    output logic       SR_CLR,
    output logic       WRITE,
    output logic [7:0] SND_DATA,
    output logic       TE,
    output logic       RE,
    output logic       READ,
    input  logic       SND_EMPTY,
    input  logic       RCV_FULL,
    input  logic [7:0] RCV_DATA
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CLEAR    = 3'd1;
    localparam logic [2:0] LOAD     = 3'd2;
    localparam logic [2:0] CS_SETUP = 3'd3;
    localparam logic [2:0] SHIFT    = 3'd4;
    localparam logic [2:0] CAPTURE  = 3'd5;
    localparam logic [2:0] CS_HOLD  = 3'd6;

    localparam logic [7:0] LAST = 8'(HALF_DIV - 1);

    logic [2:0] state;
    logic [2:0] state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic [3:0] bits;
    logic [3:0] bits_n;
    logic       sclk_n;

    // Next-state, half-period counter, SCLK toggle and bit counter
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bits_n  = bits;
        sclk_n  = SCLK;
        case (state)
            IDLE: begin
                cnt_n  = 8'd0;
                bits_n = 4'd0;
                sclk_n = 1'b0;
                if (START) state_n = CLEAR;
            end
            CLEAR: state_n = LOAD;
            LOAD: begin
                cnt_n   = 8'd0;
                state_n = CS_SETUP;
            end
            CS_SETUP: begin
                if (cnt == LAST) begin
                    cnt_n   = 8'd0;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    cnt_n  = 8'd0;
                    sclk_n = ~SCLK;
                    if (SCLK) begin
                        bits_n = bits + 4'd1;
                        if (bits == 4'd7) state_n = CAPTURE;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            CAPTURE: begin
                cnt_n   = 8'd0;
                state_n = CS_HOLD;
            end
            CS_HOLD: begin
                if (cnt == LAST) begin
                    cnt_n   = 8'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and all registered outputs decoded from the next state
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            bits     <= 4'd0;
            SCLK     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            RX_DATA  <= 8'h00;
            CS_N     <= 1'b1;
            SR_CLR   <= 1'b0;
            WRITE    <= 1'b0;
            SND_DATA <= 8'h00;
            TE       <= 1'b0;
            RE       <= 1'b0;
            READ     <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bits   <= bits_n;
            SCLK   <= sclk_n;
            BUSY   <= (state_n != IDLE);
            DONE   <= (state == CS_HOLD) && (state_n == IDLE);
            CS_N   <= !((state_n == CS_SETUP) || (state_n == SHIFT) ||
                        (state_n == CAPTURE) || (state_n == CS_HOLD));
            SR_CLR <= (state_n == CLEAR);
            WRITE  <= (state_n == LOAD);
            TE     <= (state_n == SHIFT);
            RE     <= (state_n == SHIFT);
            READ   <= (state_n == CAPTURE);
            if ((state == IDLE) && START) begin
                SND_DATA <= TX_DATA;
                ERR      <= 1'b0;
            end
            if (state == CAPTURE) begin
                RX_DATA <= RCV_DATA;
                if (!SND_EMPTY || !RCV_FULL) ERR <= 1'b1;
            end
        end
    end

endmodule
